bcd2_binary: RTL and testbench

BCD2_BINARY -- requirements
Module: bcd2_binary

---
 rtl/bcd2_binary.sv | 114 +++++++++++
 tb/tb_bcd2_binary.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd2_binary.sv
// bcd2_binary: four-digit packed BCD to 14-bit binary converter.
// Reverse double-dabble, one shift per clock, 14 steps per request.
module bcd2_binary (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] bcd_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [13:0] bin_out
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FAIL
  } state_t;

  state_t      state, state_d;
  logic [15:0] dig, dig_d;
  logic [13:0] acc, acc_d;
  logic [3:0]  cnt, cnt_d;
  logic        busy_d, done_d, err_d;
  logic [13:0] bin_d;

  logic        valid_in;
  logic [29:0] shf;
  logic [15:0] dig_fix;

  // Operand check: every nibble must be a decimal digit.
  always_comb begin
    valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) valid_in = 1'b0;
    end
  end

  // One step: shift right, then pull shifted nibbles >= 8 back by 3.
  always_comb begin
    shf     = {dig, acc} >> 1;
    dig_fix = shf[29:14];
    for (int i = 0; i < 4; i++) begin
      if (shf[14+4*i+3]) dig_fix[4*i +: 4] = shf[14+4*i +: 4] - 4'd3;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d = state;
    dig_d   = dig;
    acc_d   = acc;
    cnt_d   = cnt;
    busy_d  = busy;
    done_d  = 1'b0;
    err_d   = err;
    bin_d   = bin_out;
    unique case (state)
      IDLE: begin
        if (start) begin
          dig_d   = bcd_in;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = valid_in ? CONV : FAIL;
        end
      end
      CONV: begin
        dig_d = dig_fix;
        acc_d = shf[13:0];
        cnt_d = cnt + 4'd1;
        if (cnt == 4'd13) begin
          bin_d   = shf[13:0];
          err_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      FAIL: begin
        bin_d   = '0;
        err_d   = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dig     <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      bin_out <= '0;
    end else begin
      state   <= state_d;
      dig     <= dig_d;
      acc     <= acc_d;
      cnt     <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
      bin_out <= bin_d;
    end
  end

endmodule

// File: tb/tb_bcd2_binary.sv
// tb_bcd2_binary: directed and randomized checks of bcd2_binary.
// Four lanes run the full 0..9999 sweep in parallel.
module tb_bcd2_binary;

  localparam int L = 4;

  logic        clk;
  logic        rst_n;
  logic        start_v [L];
  logic [15:0] bcd_v   [L];
  logic        busy_v  [L];
  logic        done_v  [L];
  logic        err_v   [L];
  logic [13:0] bin_v   [L];

  int n_chk;
  int n_fail;
  int cyc;

  for (genvar g = 0; g < L; g++) begin : g_lane
    bcd2_binary u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start_v[g]),
      .bcd_in  (bcd_v[g]),
      .busy    (busy_v[g]),
      .done    (done_v[g]),
      .err     (err_v[g]),
      .bin_out (bin_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  // Reference: decimal value of the digits, or error if any digit > 9.
  task automatic model(input logic [15:0] b, output int v, output logic e);
    int d;
    v = 0;
    e = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) e = 1'b1;
      v = v * 10 + d;
    end
    if (e) v = 0;
  endtask

  // Issue one request on lane 0 at the current negedge and check it.
  task automatic conv0(input logic [15:0] b, input int exp_bin,
                       input logic exp_err, input int exp_lat,
                       input string tag);
    int k;
    int nb;
    start_v[0] = 1'b1;
    bcd_v[0]   = b;
    @(negedge clk);
    start_v[0] = 1'b0;
    bcd_v[0]   = 16'($urandom);
    k  = 1;
    nb = 0;
    while (!done_v[0] && k < 40) begin
      if (busy_v[0]) nb++;
      @(negedge clk);
      k++;
    end
    check({tag, "_seen"}, int'(done_v[0]), 1);
    check({tag, "_lat"}, k - 1, exp_lat);
    check({tag, "_busy"}, nb, exp_lat);
    check({tag, "_bin"}, int'(bin_v[0]), exp_bin);
    check({tag, "_err"}, int'(err_v[0]), int'(exp_err));
    check({tag, "_bdone"}, int'(busy_v[0]), 0);
    @(negedge clk);
    check({tag, "_pulse"}, int'(done_v[0]), 0);
  endtask

  initial begin
    int ndone, kd, bd, c1, c2, k, eb, j, t;
    logic ee;
    logic [15:0] b;
    int perm [10000];
    int exp_v [L];

    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    for (int g = 0; g < L; g++) begin
      start_v[g] = 1'b0;
      bcd_v[g]   = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy_v[0]), 0);
    check("rst_done", int'(done_v[0]), 0);
    check("rst_err", int'(err_v[0]), 0);
    check("rst_bin", int'(bin_v[0]), 0);

    rst_n = 1'b1;
    conv0(16'h9999, 9999, 1'b0, 14, "h9999");
    conv0(16'h1234, 1234, 1'b0, 14, "h1234");
    conv0(16'h0000, 0, 1'b0, 14, "h0000");
    conv0(16'h12A4, 0, 1'b1, 1, "h12A4");
    conv0(16'h0042, 42, 1'b0, 14, "h0042");

    // Start re-asserted mid-conversion is ignored.
    start_v[0] = 1'b1;
    bcd_v[0]   = 16'h0500;
    ndone = 0;
    kd    = 0;
    bd    = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done_v[0]) begin
        ndone++;
        kd = i;
        bd = int'(bin_v[0]);
      end
      start_v[0] = (i == 5);
      if (i == 5) bcd_v[0] = 16'h9999;
    end
    check("ign_ndone", ndone, 1);
    check("ign_lat", kd - 1, 14);
    check("ign_bin", bd, 500);

    // Back-to-back, second start in the done cycle.
    start_v[0] = 1'b1;
    bcd_v[0]   = 16'h0007;
    @(negedge clk);
    start_v[0] = 1'b0;
    k = 1;
    while (!done_v[0] && k < 40) begin
      @(negedge clk);
      k++;
    end
    c1 = cyc;
    check("b2b_bin1", int'(bin_v[0]), 7);
    start_v[0] = 1'b1;
    bcd_v[0]   = 16'h8191;
    @(negedge clk);
    start_v[0] = 1'b0;
    k = 1;
    while (!done_v[0] && k < 40) begin
      @(negedge clk);
      k++;
    end
    c2 = cyc;
    check("b2b_gap", c2 - c1, 15);
    check("b2b_bin2", int'(bin_v[0]), 8191);
    @(negedge clk);

    // Reset in the middle of a conversion.
    start_v[0] = 1'b1;
    bcd_v[0]   = 16'h4321;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_busy", int'(busy_v[0]), 0);
    check("mid_done", int'(done_v[0]), 0);
    check("mid_err", int'(err_v[0]), 0);
    check("mid_bin", int'(bin_v[0]), 0);
    ndone = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
    end
    check("mid_nodone", ndone, 0);
    rst_n = 1'b1;
    conv0(16'h0321, 321, 1'b0, 14, "post_rst");

    // Random operands, valid and invalid, against the model.
    for (int i = 0; i < 200; i++) begin
      b = 16'($urandom);
      if (i % 2 == 0) b = to_bcd(int'($urandom_range(9999)));
      model(b, eb, ee);
      conv0(b, eb, ee, ee ? 1 : 14, "rand");
    end

    // Every valid operand, in shuffled order, across the lanes.
    for (int i = 0; i < 10000; i++) perm[i] = i;
    for (int i = 9999; i > 0; i--) begin
      j = int'($urandom_range(i));
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int s = 0; s < 10000 / L; s++) begin
      for (int g = 0; g < L; g++) begin
        exp_v[g]   = perm[g * (10000 / L) + s];
        bcd_v[g]   = to_bcd(exp_v[g]);
        start_v[g] = 1'b1;
      end
      @(negedge clk);
      for (int g = 0; g < L; g++) begin
        start_v[g] = 1'b0;
        bcd_v[g]   = 16'($urandom);
      end
      k = 1;
      while (!done_v[0] && k < 40) begin
        @(negedge clk);
        k++;
      end
      for (int g = 0; g < L; g++) begin
        check("sweep_done", int'(done_v[g]), 1);
        check("sweep_bin", int'(bin_v[g]), exp_v[g]);
        check("sweep_err", int'(err_v[g]), 0);
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
